// File: rtl/scroll_pkg.sv
// Shared definitions for the scroll position generator: CPU register
// address fields, arbitration FSM encoding, tile-phase constants and the
// byte-merge helper used for 8-bit CPU writes into wider offset registers.
package scroll_pkg;

  // cpu_addr layout: {layer, hv, byte}
  localparam int LAYER_SHIFT = 2;
  localparam int HV_BIT      = 1;
  localparam int BYTE_BIT    = 0;

  // Tile phases that produce strobes
  localparam int PH_S0 = 0;
  localparam int PH_S2 = 2;
  localparam int PH_S4 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  // Replace the low (sel=0) or high (sel=1) byte of a 16-bit register image
  function automatic logic [15:0] byte_merge(input logic [15:0] old,
                                             input logic        sel,
                                             input logic [7:0]  data);
    logic [15:0] res;
    res = old;
    if (sel) begin
      res[15:8] = data;
    end else begin
      res[7:0] = data;
    end
    return res;
  endfunction

endpackage

// File: rtl/scroll_layer_regs.sv
// One tilemap layer: CPU-written shadow H/V offsets, atomic commit to the
// active offsets on the VBLANK rising edge (a write landing in the same cycle
// as the commit is forwarded straight into the active copy), and the
// registered scroll adders. Offsets up to 16 bits wide are supported; the
// high byte only fills bits [W-1:8], extra data bits are dropped.
module scroll_layer_regs
  import scroll_pkg::*;
#(
  parameter int H_WIDTH = 9,
  parameter int V_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [H_WIDTH-1:0] hsrc,
  input  logic [V_WIDTH-1:0] vsrc,
  input  logic               vb_rise,
  input  logic               we,
  input  logic               hv_sel,
  input  logic               byte_sel,
  input  logic [7:0]         wdata,
  output logic [H_WIDTH-1:0] sh_next,
  output logic [H_WIDTH-1:0] sh,
  output logic [V_WIDTH-1:0] sv
);

  logic [H_WIDTH-1:0] hoff_shadow;
  logic [H_WIDTH-1:0] hoff_active;
  logic [H_WIDTH-1:0] hoff_shadow_nx;
  logic [V_WIDTH-1:0] voff_shadow;
  logic [V_WIDTH-1:0] voff_active;
  logic [V_WIDTH-1:0] voff_shadow_nx;
  logic [V_WIDTH-1:0] sv_next;

  // Merge an incoming CPU byte into the addressed shadow offset
  always_comb begin
    hoff_shadow_nx = hoff_shadow;
    voff_shadow_nx = voff_shadow;
    if (we && !hv_sel) begin
      hoff_shadow_nx = H_WIDTH'(byte_merge(16'(hoff_shadow), byte_sel, wdata));
    end else if (we && hv_sel) begin
      voff_shadow_nx = V_WIDTH'(byte_merge(16'(voff_shadow), byte_sel, wdata));
    end else begin
      hoff_shadow_nx = hoff_shadow;
      voff_shadow_nx = voff_shadow;
    end
  end

  // Scroll adders; wrap-around at the raster size is intentional
  always_comb begin
    sh_next = hsrc + hoff_active;
    sv_next = vsrc + voff_active;
  end

  // Shadow update, VBLANK commit (with same-cycle write forwarding) and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hoff_shadow <= '0;
      voff_shadow <= '0;
      hoff_active <= '0;
      voff_active <= '0;
      sh          <= '0;
      sv          <= '0;
    end else begin
      hoff_shadow <= hoff_shadow_nx;
      voff_shadow <= voff_shadow_nx;
      if (vb_rise) begin
        hoff_active <= hoff_shadow_nx;
        voff_active <= voff_shadow_nx;
      end
      sh <= sh_next;
      sv <= sv_next;
    end
  end

endmodule

// File: rtl/scroll_position_gen.sv
// Multi-layer scroll position generator. Produces registered scrolled
// pixel coordinates for NUM_LAYERS tilemap layers, layer-0 tile-phase
// strobes, and arbitrates CPU scroll-RAM access into the S4H window using a
// wait-state handshake (nMRDY2) and a one-cycle enable (nSCREN).
// Build option: define SCROLL_VFLIP_EN to let FLIP also invert V before the
// vertical add; left undefined, V is always used unflipped.
module scroll_position_gen
  import scroll_pkg::*;
#(
  parameter int H_WIDTH    = 9,
  parameter int V_WIDTH    = 9,
  parameter int NUM_LAYERS = 2,
  parameter int TILE_LOG2  = 3
) (
  input  logic                             CLK_6M,
  input  logic                             rst,
  input  logic                             FLIP,
  input  logic [H_WIDTH-1:0]               H,
  input  logic [V_WIDTH-1:0]               V,
  input  logic                             VBLANK,
  input  logic [$clog2(NUM_LAYERS)+1:0]    cpu_addr,
  input  logic [7:0]                       cpu_wdata,
  input  logic                             cpu_we,
  input  logic                             nSCRCS,
  output logic [NUM_LAYERS*H_WIDTH-1:0]    SH,
  output logic [NUM_LAYERS*V_WIDTH-1:0]    SV,
  output logic                             S0H,
  output logic                             S2H,
  output logic                             S4H,
  output logic                             nS7H,
  output logic                             nSCREN,
  output logic                             nMRDY2
);

  localparam int PH_LAST = (2 ** TILE_LOG2) - 1;

  logic                          vblank_q;
  logic                          vb_rise;
  logic [H_WIDTH-1:0]            hsrc;
  logic [V_WIDTH-1:0]            vsrc;
  int unsigned                   layer_sel;
  logic                          hv_sel;
  logic                          byte_sel;
  logic [NUM_LAYERS*H_WIDTH-1:0] sh_next_all;
  logic [H_WIDTH-1:0]            sh_next0;
  logic [TILE_LOG2-1:0]          ph;
  int                            ph_val;
  logic                          ph_s0;
  logic                          ph_s2;
  logic                          ph_s4;
  logic                          ph_last;
  logic                          win;
  arb_state_t                    state;
  logic                          unused_sh_next;

  // Only layer 0 drives the phase decode; the other layers' next values are sinks
  assign unused_sh_next = ^sh_next_all;

  // Screen-flip source selection for the adders
  always_comb begin
    if (FLIP) begin
      hsrc = ~H;
    end else begin
      hsrc = H;
    end
`ifdef SCROLL_VFLIP_EN
    if (FLIP) begin
      vsrc = ~V;
    end else begin
      vsrc = V;
    end
`else
    vsrc = V;
`endif
  end

  // Register-select decode and VBLANK rising-edge detect
  always_comb begin
    layer_sel = 32'(cpu_addr >> LAYER_SHIFT);
    hv_sel    = cpu_addr[HV_BIT];
    byte_sel  = cpu_addr[BYTE_BIT];
    vb_rise   = VBLANK & ~vblank_q;
  end

  // Remember VBLANK so its rising edge can be found
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= VBLANK;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
      logic layer_we;
      // Writes to a layer index that does not exist match no instance
      assign layer_we = cpu_we & (layer_sel == 32'(g));

      scroll_layer_regs #(
        .H_WIDTH (H_WIDTH),
        .V_WIDTH (V_WIDTH)
      ) u_regs (
        .clk      (CLK_6M),
        .rst      (rst),
        .hsrc     (hsrc),
        .vsrc     (vsrc),
        .vb_rise  (vb_rise),
        .we       (layer_we),
        .hv_sel   (hv_sel),
        .byte_sel (byte_sel),
        .wdata    (cpu_wdata),
        .sh_next  (sh_next_all[g*H_WIDTH +: H_WIDTH]),
        .sh       (SH[g*H_WIDTH +: H_WIDTH]),
        .sv       (SV[g*V_WIDTH +: V_WIDTH])
      );
    end
  endgenerate

  // Tile phase of the layer-0 position about to be registered
  always_comb begin
    sh_next0 = sh_next_all[H_WIDTH-1:0];
    if (FLIP) begin
      ph = ~sh_next0[TILE_LOG2-1:0];
    end else begin
      ph = sh_next0[TILE_LOG2-1:0];
    end
    ph_val  = 32'(ph);
    ph_s0   = (ph_val == PH_S0);
    ph_s2   = (ph_val == PH_S2);
    ph_s4   = (ph_val == PH_S4);
    ph_last = (ph_val == PH_LAST);
    win     = ph_s4;
  end

  // Registered tile-phase strobes, aligned with the registered SH
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      S0H  <= 1'b0;
      S2H  <= 1'b0;
      S4H  <= 1'b0;
      nS7H <= 1'b1;
    end else begin
      S0H  <= ph_s0;
      S2H  <= ph_s2;
      S4H  <= ph_s4;
      nS7H <= ~ph_last;
    end
  end

  // CPU arbitration: one scroll-RAM grant per chip-select assertion, placed in the S4H cycle
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      state  <= IDLE;
      nSCREN <= 1'b1;
      nMRDY2 <= 1'b1;
    end else begin
      nSCREN <= 1'b1;
      nMRDY2 <= 1'b1;
      case (state)
        IDLE: begin
          if (!nSCRCS) begin
            if (win) begin
              state  <= GRANT;
              nSCREN <= 1'b0;
            end else begin
              state  <= WAIT;
              nMRDY2 <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (nSCRCS) begin
            state <= IDLE;
          end else if (win) begin
            state  <= GRANT;
            nSCREN <= 1'b0;
          end else begin
            state  <= WAIT;
            nMRDY2 <= 1'b0;
          end
        end
        GRANT: begin
          state <= HOLD;
        end
        HOLD: begin
          if (nSCRCS) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
